pipe_stage_reg: RTL and testbench

- Generic, parametrised pipeline stage register for the IF/ID/EX/MEM/WB boundaries.
- Splits each stage's signals into a control bundle, which is forced to a NOP pattern on bubbles, and a datapath bundle, which is held on bubbles.
- Adds valid/ready flow control, flush (bubble insertion) and an optional 2-entry skid mode. The core can stall and flush at every boundary without hand-written per-stage registers.

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/pipe_slot.sv | 43 ++++
 rtl/pipe_stage_reg.sv | 161 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the generic pipeline stage register.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam int OCC_W = 2;

    // Per-stage bundle widths (ID/EX boundary shown; others follow the same pattern)
    localparam int IDEX_CTRL_W = 16;
    localparam int IDEX_DATA_W = 32*4 + 5*3 + 26;

    // All-zero control: no register write, no memory access
    localparam logic [IDEX_CTRL_W-1:0] CTRL_NOP_DEFAULT = '0;

    // Number of entries held in a given state
    function automatic logic [OCC_W-1:0] occ_of(input state_t s);
        case (s)
            ST_EMPTY: occ_of = 2'd0;
            ST_BUSY:  occ_of = 2'd1;
            ST_FULL:  occ_of = 2'd2;
            default:  occ_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: control + datapath register with valid bit.
// Clearing forces control to the NOP pattern while the datapath holds.
module pipe_slot #(
    parameter int                CTRL_W   = 16,
    parameter int                DATA_W   = 32,
    parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    // Entry register: reset > clear > load; datapath only changes on reset or load
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_NOP;
            r_data  <= '0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_NOP;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= i_ctrl;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready flow control, flush
// and an optional 2-entry skid buffer (SKID=1, registered in_ready).
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                CTRL_W   = 16,
    parameter logic [CTRL_W-1:0] CTRL_NOP = CTRL_W'(CTRL_NOP_DEFAULT),
    parameter int                SKID     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [OCC_W-1:0]  occupancy
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_load_out;
    logic              w_clr_out;
    logic              w_load_skid;
    logic              w_clr_skid;
    logic              w_out_valid;
    logic              w_skid_valid;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;
    logic [CTRL_W-1:0] w_out_src_ctrl;
    logic [DATA_W-1:0] w_out_src_data;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = w_out_valid & out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and slot load/clear decode; flush overrides normal flow
    always_comb begin
        w_state_nxt = r_state;
        w_load_out  = 1'b0;
        w_clr_out   = 1'b0;
        w_load_skid = 1'b0;
        w_clr_skid  = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_clr_out   = 1'b1;
            w_clr_skid  = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt = ST_BUSY;
                        w_load_out  = 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (w_in_fire && w_out_fire) begin
                        w_load_out = 1'b1;
                    end else if (w_in_fire) begin
                        if (SKID != 0) begin
                            w_state_nxt = ST_FULL;
                            w_load_skid = 1'b1;
                        end else begin
                            w_load_out = 1'b1;
                        end
                    end else if (w_out_fire) begin
                        w_state_nxt = ST_EMPTY;
                        w_clr_out   = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_state_nxt = ST_BUSY;
                        w_load_out  = 1'b1;
                        w_clr_skid  = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // A valid skid entry is always older than the input beat, so it refills the output first
    assign w_out_src_ctrl = w_skid_valid ? w_skid_ctrl : in_ctrl;
    assign w_out_src_data = w_skid_valid ? w_skid_data : in_data;

    pipe_slot #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .CTRL_NOP (CTRL_NOP)
    ) u_out_slot (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr_out),
        .i_load  (w_load_out),
        .i_ctrl  (w_out_src_ctrl),
        .i_data  (w_out_src_data),
        .o_valid (w_out_valid),
        .o_ctrl  (out_ctrl),
        .o_data  (out_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic r_in_ready;

            pipe_slot #(
                .CTRL_W   (CTRL_W),
                .DATA_W   (DATA_W),
                .CTRL_NOP (CTRL_NOP)
            ) u_skid_slot (
                .clk     (clk),
                .rst     (rst),
                .i_clr   (w_clr_skid),
                .i_load  (w_load_skid),
                .i_ctrl  (in_ctrl),
                .i_data  (in_data),
                .o_valid (w_skid_valid),
                .o_ctrl  (w_skid_ctrl),
                .o_data  (w_skid_data)
            );

            // Registered ready: accept next cycle unless the stage is about to be full
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_in_ready <= 1'b1;
                end else begin
                    r_in_ready <= (w_state_nxt != ST_FULL);
                end
            end

            assign in_ready = r_in_ready;
        end else begin : g_noskid
            assign w_skid_valid = 1'b0;
            assign w_skid_ctrl  = CTRL_NOP;
            assign w_skid_data  = '0;
            assign in_ready     = ~w_out_valid | out_ready;
        end
    endgenerate

    assign out_valid = w_out_valid;
    assign occupancy = occ_of(r_state);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: SKID=1 and SKID=0 instances share one stimulus stream
// and are each compared against a queue-based transaction model.
module tb_pipe_stage_reg;

    localparam int          CW  = 16;
    localparam int          DW  = 32;
    localparam logic [15:0] NOP = 16'hA000;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          in_ready1, out_valid1;
    logic [CW-1:0] out_ctrl1;
    logic [DW-1:0] out_data1;
    logic [1:0]    occ1;

    logic          in_ready0, out_valid0;
    logic [CW-1:0] out_ctrl0;
    logic [DW-1:0] out_data0;
    logic [1:0]    occ0;

    int checks = 0;
    int errors = 0;

    logic [CW+DW-1:0] q1[$];
    logic [CW+DW-1:0] q0[$];
    logic [DW-1:0]    last1 = '0;
    logic [DW-1:0]    last0 = '0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_NOP(NOP), .SKID(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_ctrl(out_ctrl1),
        .out_data(out_data1), .occupancy(occ1)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_NOP(NOP), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0),
        .out_data(out_data0), .occupancy(occ0)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Compare registered outputs of both instances with the model
    task automatic check_outs();
        chk("s1_valid", 64'(out_valid1), 64'(q1.size() > 0));
        chk("s1_ctrl",  64'(out_ctrl1),  64'((q1.size() > 0) ? q1[0][CW+DW-1:DW] : NOP));
        chk("s1_data",  64'(out_data1),  64'((q1.size() > 0) ? q1[0][DW-1:0] : last1));
        chk("s1_occ",   64'(occ1),       64'(q1.size()));
        chk("s1_ready", 64'(in_ready1),  64'(q1.size() != 2));
        chk("s0_valid", 64'(out_valid0), 64'(q0.size() > 0));
        chk("s0_ctrl",  64'(out_ctrl0),  64'((q0.size() > 0) ? q0[0][CW+DW-1:DW] : NOP));
        chk("s0_data",  64'(out_data0),  64'((q0.size() > 0) ? q0[0][DW-1:0] : last0));
        chk("s0_occ",   64'(occ0),       64'(q0.size()));
    endtask

    // One cycle: check at negedge, drive inputs, advance the model to the next edge
    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [CW-1:0] c, input logic [DW-1:0] d, input logic orr);
        bit ir1, ir0;
        check_outs();
        rst       = r;
        flush     = f;
        in_valid  = iv;
        in_ctrl   = c;
        in_data   = d;
        out_ready = orr;
        #1;
        ir1 = (q1.size() != 2);
        ir0 = (q0.size() == 0) || orr;
        chk("s0_ready_comb", 64'(in_ready0), 64'(ir0));
        if (r) begin
            q1.delete(); q0.delete();
            last1 = '0;  last0 = '0;
        end else if (f) begin
            q1.delete(); q0.delete();
        end else begin
            if (q1.size() > 0 && orr) void'(q1.pop_front());
            if (iv && ir1) q1.push_back({c, d});
            if (q1.size() > 0) last1 = q1[0][DW-1:0];
            if (q0.size() > 0 && orr) void'(q0.pop_front());
            if (iv && ir0) q0.push_back({c, d});
            if (q0.size() > 0) last0 = q0[0][DW-1:0];
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset values
        chk("rst_occ1",  64'(occ1), 64'd0);
        chk("rst_data1", 64'(out_data1), 64'd0);
        chk("rst_ctrl1", 64'(out_ctrl1), 64'(NOP));

        // Pass-through then 8-beat stream
        step(0, 0, 1, 16'h0005, 32'h40, 1);
        chk("pass_ctrl", 64'(out_ctrl1), 64'h5);
        chk("pass_data", 64'(out_data1), 64'h40);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 16'(i + 1), 32'h100 + 32'(i), 1);
        chk("stream_last", 64'(out_data1), 64'h107);
        step(0, 0, 0, '0, '0, 1);

        // Stall fill with A, B
        step(0, 0, 1, 16'h0011, 32'h11, 0);
        chk("fill_occ1", 64'(occ1), 64'd1);
        step(0, 0, 1, 16'h0022, 32'h22, 0);
        chk("fill_occ2", 64'(occ1), 64'd2);
        chk("fill_nrdy", 64'(in_ready1), 64'd0);
        chk("s0_stall_nrdy", 64'(in_ready0), 64'd0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 16'h0099, 32'h99, 0);
            chk("stall_hold", 64'(out_data1), 64'h11);
        end
        step(0, 0, 0, '0, '0, 1);
        chk("drain_b", 64'(out_data1), 64'h22);
        chk("drain_rdy", 64'(in_ready1), 64'd1);
        step(0, 0, 0, '0, '0, 1);

        // Flush while FULL with C offered
        step(0, 0, 1, 16'h0011, 32'h11, 0);
        step(0, 0, 1, 16'h0022, 32'h22, 0);
        step(0, 1, 1, 16'h0033, 32'h33, 0);
        chk("flush_valid", 64'(out_valid1), 64'd0);
        chk("flush_ctrl",  64'(out_ctrl1),  64'(NOP));
        chk("flush_occ",   64'(occ1),       64'd0);
        step(0, 0, 0, '0, '0, 1);
        step(0, 0, 0, '0, '0, 1);

        // Simultaneous in/out fire in BUSY
        step(0, 0, 1, 16'h0100, 32'h200, 1);
        for (int i = 1; i < 7; i++) begin
            step(0, 0, 1, 16'h0100 + 16'(i), 32'h200 + 32'(i), 1);
            chk("busy_occ", 64'(occ1), 64'd1);
        end
        step(0, 0, 0, '0, '0, 1);

        // Reset mid-operation while FULL
        step(0, 0, 1, 16'h0044, 32'h44, 0);
        step(0, 0, 1, 16'h0045, 32'h45, 0);
        step(1, 0, 1, 16'h0055, 32'h55, 1);
        chk("mrst_data", 64'(out_data1), 64'd0);
        chk("mrst_rdy",  64'(in_ready1), 64'd1);
        chk("mrst_occ",  64'(occ1),      64'd0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 127) == 0), ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 3) != 0), 16'($urandom), $urandom,
                 ($urandom_range(0, 2) != 0));
        end
        step(0, 0, 0, '0, '0, 1);
        check_outs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
